// File: rtl/tdm_pkg.sv
// Shared types and helpers for the TDM receive path.
package tdm_pkg;

  typedef enum logic [1:0] {IDLE, RUN, PAR} state_e;

  localparam int TDM_NCH = 2;
  localparam int TDM_W   = 2;

  // Minimum width 1 so single-value counters still get a real bit.
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return (r == 0) ? 1 : r;
  endfunction

endpackage

// File: rtl/tdm_shift_in.sv
// Serial-in shift register; clr restarts the contents with the incoming bit.
// sr_nxt_o is the combinational next contents, so a frame can be taken on the same edge as its last bit.
module tdm_shift_in
  import tdm_pkg::*;
#(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en_i,
  input  logic         clr_i,
  input  logic         din_i,
  output logic [N-1:0] sr_nxt_o
);

  logic [N-1:0] sr_q, sr_d;

  always_comb begin
    sr_d = sr_q;
    if (en_i) sr_d = clr_i ? {{(N-1){1'b0}}, din_i} : {sr_q[N-2:0], din_i};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sr_q <= '0;
    else        sr_q <= sr_d;
  end

  assign sr_nxt_o = sr_d;

endmodule

// File: rtl/tdm_demux.sv
// TDM serial-to-parallel demux: NCH slots of W bits, MSB first, framed by fs.
// Optional trailing even-parity bit when TDM_PARITY_EN is defined.
module tdm_demux
  import tdm_pkg::*;
#(
  parameter int NCH = TDM_NCH,
  parameter int W   = TDM_W
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   en,
  input  logic                   fs,
  input  logic                   din,
  output logic [clog2(NCH)-1:0]  sel,
  output logic [NCH*W-1:0]       dout,
  output logic                   dvalid,
`ifdef TDM_PARITY_EN
  output logic                   par_err,
`endif
  output logic                   sync_err
);

  localparam int N  = NCH * W;
  localparam int SW = clog2(NCH);
  localparam int BW = clog2(W);
  // Counter position after the first frame bit has been taken.
  localparam logic [BW-1:0] BIT1  = (W == 1) ? '0 : BW'(1);
  localparam logic [SW-1:0] SLOT1 = (W == 1) ? SW'(1) : '0;

  state_e          state_q, state_d;
  logic [BW-1:0]   bit_q, bit_d;
  logic [SW-1:0]   slot_q, slot_d;
  logic [N-1:0]    dout_q, dout_nx, sr_nxt;
  logic            dvalid_q, serr_q, serr_d;
  logic            sh_en, sh_clr, load;
  logic            last_bit, last_slot;

  tdm_shift_in #(.N(N)) u_shift (
    .clk      (clk),
    .rst_n    (rst_n),
    .en_i     (sh_en),
    .clr_i    (sh_clr),
    .din_i    (din),
    .sr_nxt_o (sr_nxt)
  );

  // The first received slot sits at the top of the shift register but belongs in dout channel 0.
  for (genvar k = 0; k < NCH; k++) begin : g_reorder
    assign dout_nx[k*W +: W] = sr_nxt[(NCH-1-k)*W +: W];
  end

  assign last_bit  = (bit_q == BW'(W - 1));
  assign last_slot = (slot_q == SW'(NCH - 1));

`ifdef TDM_PARITY_EN
  logic perr_q, perr_d;
`endif

  always_comb begin
    state_d = state_q;
    bit_d   = bit_q;
    slot_d  = slot_q;
    sh_en   = 1'b0;
    sh_clr  = 1'b0;
    load    = 1'b0;
    serr_d  = 1'b0;
`ifdef TDM_PARITY_EN
    perr_d  = 1'b0;
`endif
    if (en) begin
      unique case (state_q)
        IDLE: begin
          if (fs) begin
            sh_en   = 1'b1;
            sh_clr  = 1'b1;
            state_d = RUN;
            bit_d   = BIT1;
            slot_d  = SLOT1;
          end
        end
        RUN: begin
          sh_en = 1'b1;
          // RUN never sits on frame bit 0, so any fs here is a resync.
          if (fs) begin
            sh_clr = 1'b1;
            serr_d = 1'b1;
            bit_d  = BIT1;
            slot_d = SLOT1;
          end else if (last_bit && last_slot) begin
            bit_d  = '0;
            slot_d = '0;
`ifdef TDM_PARITY_EN
            state_d = PAR;
`else
            state_d = IDLE;
            load    = 1'b1;
`endif
          end else if (last_bit) begin
            bit_d  = '0;
            slot_d = slot_q + 1'b1;
          end else begin
            bit_d = bit_q + 1'b1;
          end
        end
        PAR: begin
          state_d = IDLE;
          if (fs) begin
            sh_en   = 1'b1;
            sh_clr  = 1'b1;
            serr_d  = 1'b1;
            state_d = RUN;
            bit_d   = BIT1;
            slot_d  = SLOT1;
          end else begin
            load = 1'b1;
`ifdef TDM_PARITY_EN
            perr_d = din ^ (^sr_nxt);
`endif
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      bit_q    <= '0;
      slot_q   <= '0;
      dout_q   <= '0;
      dvalid_q <= 1'b0;
      serr_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      bit_q    <= bit_d;
      slot_q   <= slot_d;
      if (load) dout_q <= dout_nx;
      dvalid_q <= load;
      serr_q   <= serr_d;
    end
  end

`ifdef TDM_PARITY_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) perr_q <= 1'b0;
    else        perr_q <= perr_d;
  end
  assign par_err = perr_q;
`endif

  assign sel      = (state_q == RUN) ? slot_q : '0;
  assign dout     = dout_q;
  assign dvalid   = dvalid_q;
  assign sync_err = serr_q;

endmodule

// File: tb/tb_tdm_demux.sv
// Bench for tdm_demux (NCH=2, W=2): expected frames are queued at stimulus time, popped on dvalid.
`timescale 10ns/1ns
module tb_tdm_demux;
  import tdm_pkg::*;

  logic       clk = 1'b0, rst_n = 1'b1, en = 1'b0, fs = 1'b0, din = 1'b0;
  logic [0:0] sel;
  logic [3:0] dout;
  logic       dvalid, sync_err;
`ifdef TDM_PARITY_EN
  logic       par_err;
`endif

  int checks = 0, errors = 0;
  logic [3:0] exp_q[$];

  tdm_demux #(.NCH(2), .W(2)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .en       (en),
    .fs       (fs),
    .din      (din),
    .sel      (sel),
    .dout     (dout),
    .dvalid   (dvalid),
`ifdef TDM_PARITY_EN
    .par_err  (par_err),
`endif
    .sync_err (sync_err)
  );

  always #1 clk = ~clk;

  always @(negedge clk) begin : mon
    logic [3:0] e;
    if (rst_n && dvalid) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL dvalid_unexpected: dout=%b with no frame pending", dout);
      end else begin
        e = exp_q.pop_front();
        if (dout !== e) begin
          errors++;
          $display("FAIL frame_dout: got %b expected %b", dout, e);
        end
      end
    end
  end

  task automatic drive(input logic f, input logic d);
    @(negedge clk);
    en = 1'b1; fs = f; din = d;
  endtask

  task automatic test_reset();
    #0.4 rst_n = 1'b0;
    #0.2;
    checks++;
    if ({dout, dvalid, sync_err, sel} !== 7'b0) begin
      errors++;
      $display("FAIL reset_outputs: got dout=%b dvalid=%b sync_err=%b sel=%b expected all 0",
               dout, dvalid, sync_err, sel);
    end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_frame();
    logic [3:0] bits;
    bits = 4'b1011;
    exp_q.push_back(4'b1110);
    for (int i = 0; i < 4; i++) begin
      drive(i == 0, bits[3-i]);
      checks++;
      if (sel !== 1'((i >= 2) ? 1 : 0)) begin
        errors++;
        $display("FAIL frame_sel%0d: got %b expected %0d", i, sel, (i >= 2) ? 1 : 0);
      end
    end
    drive(0, 0);
    checks++;
    if (dvalid !== 1'b1) begin errors++; $display("FAIL frame_latency: dvalid=%b expected 1", dvalid); end
    drive(0, 0);
    checks++;
    if (dvalid !== 1'b0 || dout !== 4'b1110) begin
      errors++;
      $display("FAIL frame_hold: dvalid=%b dout=%b expected 0 1110", dvalid, dout);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] bits;
    bits = 8'b1011_0100;
    exp_q.push_back(4'b1110);
    exp_q.push_back(4'b0001);
    for (int i = 0; i < 8; i++) begin
      drive(i == 0 || i == 4, bits[7-i]);
      if (i >= 4) begin
        checks++;
        if (dvalid !== 1'(i == 4)) begin
          errors++;
          $display("FAIL b2b_dvalid_bit%0d: got %b expected %0d", i, dvalid, i == 4);
        end
      end
    end
    drive(0, 0);
    checks++;
    if (dvalid !== 1'b1) begin errors++; $display("FAIL b2b_second_dvalid: got %b expected 1", dvalid); end
    drive(0, 0);
  endtask

  task automatic test_resync();
    logic [5:0] bits;
    logic [5:0] fsv;
    bits = 6'b10_0110;
    fsv  = 6'b10_1000;
    exp_q.push_back(4'b1001);
    for (int i = 0; i < 6; i++) begin
      drive(fsv[5-i], bits[5-i]);
      if (i >= 1) begin
        checks++;
        if (sync_err !== 1'(i == 3) || dvalid !== 1'b0) begin
          errors++;
          $display("FAIL resync_bit%0d: sync_err=%b dvalid=%b expected %0d 0", i, sync_err, dvalid, i == 3);
        end
      end
    end
    drive(0, 0);
    checks++;
    if (dvalid !== 1'b1 || sync_err !== 1'b0) begin
      errors++;
      $display("FAIL resync_done: dvalid=%b sync_err=%b expected 1 0", dvalid, sync_err);
    end
    drive(0, 0);
  endtask

  task automatic test_enable();
    exp_q.push_back(4'b1110);
    drive(1, 1);
    drive(0, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      en = 1'b0; fs = 1'b1; din = 1'b1;
      checks++;
      if (i > 0 && (sel !== 1'b1 || sync_err !== 1'b0 || dvalid !== 1'b0)) begin
        errors++;
        $display("FAIL enable_stall%0d: sel=%b sync_err=%b dvalid=%b expected 1 0 0", i, sel, sync_err, dvalid);
      end else if (i == 0 && sel !== 1'b1) begin
        errors++;
        $display("FAIL enable_stall0: sel=%b expected 1", sel);
      end
    end
    drive(0, 1);
    checks++;
    if (sel !== 1'b1 || sync_err !== 1'b0) begin
      errors++;
      $display("FAIL enable_resume: sel=%b sync_err=%b expected 1 0", sel, sync_err);
    end
    drive(0, 1);
    drive(0, 0);
    checks++;
    if (dvalid !== 1'b1) begin errors++; $display("FAIL enable_dvalid: got %b expected 1", dvalid); end
    drive(0, 0);
  endtask

  task automatic test_reset_mid();
    drive(1, 0);
    drive(0, 1);
    drive(0, 1);
    #0.5 rst_n = 1'b0;
    #0.1;
    checks++;
    if (dout !== 4'b0 || sel !== 1'b0 || dvalid !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid: dout=%b sel=%b dvalid=%b expected 0000 0 0", dout, sel, dvalid);
    end
    @(negedge clk);
    en = 1'b0; fs = 1'b0;
    rst_n = 1'b1;
    repeat (3) drive(0, 1);
    checks++;
    if (dout !== 4'b0 || dvalid !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_after: dout=%b dvalid=%b expected 0000 0", dout, dvalid);
    end
  endtask

`ifdef TDM_PARITY_EN
  task automatic test_parity();
    logic [4:0] bits;
    for (int p = 1; p >= 0; p--) begin
      bits = {4'b1011, 1'(p)};
      exp_q.push_back(4'b1110);
      for (int i = 0; i < 5; i++) drive(i == 0, bits[4-i]);
      drive(0, 0);
      checks++;
      if (dvalid !== 1'b1 || par_err !== 1'(p == 0)) begin
        errors++;
        $display("FAIL parity_p%0d: dvalid=%b par_err=%b expected 1 %0d", p, dvalid, par_err, p == 0);
      end
      drive(0, 0);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_frame();
    test_back_to_back();
    test_resync();
    test_enable();
    test_reset_mid();
`ifdef TDM_PARITY_EN
    test_parity();
`endif
    repeat (3) drive(0, 0);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL frames_pending: %0d expected frames never delivered, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
